// File: rtl/triangle_burst_sequencer_if.sv
// -----------------------------------------------------------------------------
// triangle_burst_sequencer_if
//   Control-side bundle of the triangle burst sequencer: per-requester level
//   requests and durations, the abort strobe, and every registered result the
//   sequencer returns (grant, generator drive, completion report).
//
//   master : control logic (buttons / CPU regs) - drives requests, sees results
//   slave  : triangle_burst_sequencer           - sees requests, drives results
//
//   req_in       N_REQ      level request per requester
//   duration_in  N_REQ*D    requester i's duration at [i*D +: D]
//   abort_in     1          cancel the running burst
//   grant_out    N_REQ      one-hot acceptance pulse
//   busy_out     1          sequencer not idle
//   trigger_out  1          start pulse to the generator
//   duration_out D          latched duration for the generator
//   gen_rst_out  1          generator reset pulse on abort
//   done_out     1          burst-complete pulse
//   done_id_out  clog2(N)   id of the completed burst
//   aborted_out  1          completed burst was aborted
// -----------------------------------------------------------------------------
interface triangle_burst_sequencer_if #(
    parameter int N_REQ = 4,
    parameter int D     = 8
);
    localparam int IDW = $clog2(N_REQ);

    logic [N_REQ-1:0]   req_in;
    logic [N_REQ*D-1:0] duration_in;
    logic               abort_in;
    logic [N_REQ-1:0]   grant_out;
    logic               busy_out;
    logic               trigger_out;
    logic [D-1:0]       duration_out;
    logic               gen_rst_out;
    logic               done_out;
    logic [IDW-1:0]     done_id_out;
    logic               aborted_out;

    modport master (
        output req_in, duration_in, abort_in,
        input  grant_out, busy_out, trigger_out, duration_out,
               gen_rst_out, done_out, done_id_out, aborted_out
    );

    modport slave (
        input  req_in, duration_in, abort_in,
        output grant_out, busy_out, trigger_out, duration_out,
               gen_rst_out, done_out, done_id_out, aborted_out
    );
endinterface

// File: rtl/triangle_burst_sequencer.sv
// -----------------------------------------------------------------------------
// triangle_burst_sequencer
//   Round-robin scheduler sharing one triangle PWM generator among N_REQ
//   requesters. One request is granted at a time; the sequencer triggers the
//   generator, times the burst (duration * UNIT_CYCLES clk cycles) with its own
//   counter, reports completion, then holds off GUARD_CYCLES idle cycles before
//   arbitrating again. A burst may be cancelled with abort_in while running,
//   which also resets the generator.
//
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   bus    : slave side of triangle_burst_sequencer_if (requests in, grant /
//            generator drive / completion report out, all registered)
// -----------------------------------------------------------------------------
module triangle_burst_sequencer #(
    parameter int N_REQ        = 4,
    parameter int D            = 8,
    parameter int UNIT_CYCLES  = 131072,
    parameter int GUARD_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    triangle_burst_sequencer_if.slave bus
);
    localparam int IDW = $clog2(N_REQ);
    localparam int CW  = D + $clog2(UNIT_CYCLES);
    localparam int GW  = $clog2(GUARD_CYCLES + 1);

    localparam logic [CW-1:0]  UNIT_W      = CW'(UNIT_CYCLES);
    localparam logic [GW-1:0]  GUARD_FULL  = GW'(GUARD_CYCLES);
    localparam logic [GW-1:0]  GUARD_SHORT = GW'(GUARD_CYCLES - 1);
    localparam logic [IDW-1:0] LAST_ID     = IDW'(N_REQ - 1);
    localparam logic [N_REQ-1:0] ONE_HOT0  = {{(N_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE,
        FIRE,
        RUN,
        GUARD
    } state_t;

    state_t           state;
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   cur_id;
    logic [CW-1:0]    cnt;
    logic [GW-1:0]    guard_cnt;

    logic [N_REQ-1:0] grant_q;
    logic             busy_q;
    logic             trigger_q;
    logic [D-1:0]     duration_q;
    logic             gen_rst_q;
    logic             done_q;
    logic [IDW-1:0]   done_id_q;
    logic             aborted_q;

    // Round-robin pick: first set request at or after rr_ptr, wrapping.
    logic             pick_valid;
    logic [IDW-1:0]   pick_id;
    logic [D-1:0]     pick_dur;
    int unsigned      pick_idx;

    always_comb begin
        pick_valid = 1'b0;
        pick_id    = '0;
        pick_dur   = '0;
        pick_idx   = 0;
        // Walk the offsets from farthest to nearest so the nearest hit wins.
        for (int unsigned k = N_REQ; k > 0; k--) begin
            pick_idx = (32'(rr_ptr) + k - 1) % 32'(N_REQ);
            if (bus.req_in[pick_idx]) begin
                pick_valid = 1'b1;
                pick_id    = IDW'(pick_idx);
                pick_dur   = bus.duration_in[pick_idx*D +: D];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            cur_id     <= '0;
            cnt        <= '0;
            guard_cnt  <= '0;
            grant_q    <= '0;
            busy_q     <= 1'b0;
            trigger_q  <= 1'b0;
            duration_q <= '0;
            gen_rst_q  <= 1'b0;
            done_q     <= 1'b0;
            done_id_q  <= '0;
            aborted_q  <= 1'b0;
        end else begin
            // Pulse outputs default low; each is raised for exactly one cycle.
            grant_q   <= '0;
            trigger_q <= 1'b0;
            gen_rst_q <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;

            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        state      <= FIRE;
                        cur_id     <= pick_id;
                        rr_ptr     <= (pick_id == LAST_ID) ? '0 : pick_id + 1'b1;
                        grant_q    <= ONE_HOT0 << pick_id;
                        busy_q     <= 1'b1;
                        duration_q <= pick_dur;
                        if (pick_dur != '0) begin
                            trigger_q <= 1'b1;
                            cnt       <= CW'(pick_dur) * UNIT_W - CW'(1);
                        end else begin
                            // Zero-length burst completes in the grant cycle.
                            done_q    <= 1'b1;
                            done_id_q <= pick_id;
                        end
                    end
                end

                FIRE: begin
                    // The counter is loaded one cycle early and already counts
                    // here, so its zero lands on the edge that registers done_out
                    // into the last burst cycle.
                    if (duration_q == '0) begin
                        state     <= GUARD;
                        guard_cnt <= GUARD_SHORT;
                    end else if (cnt == '0) begin
                        state     <= GUARD;
                        guard_cnt <= GUARD_FULL;
                        done_q    <= 1'b1;
                        done_id_q <= cur_id;
                    end else begin
                        state <= RUN;
                        cnt   <= cnt - 1'b1;
                    end
                end

                RUN: begin
                    // Abort is tested first so it wins over a simultaneous expiry.
                    // The first GUARD cycle after a timed burst carries done_out and
                    // is not counted as guard time, hence GUARD_FULL rather than
                    // GUARD_SHORT.
                    if (bus.abort_in) begin
                        state     <= GUARD;
                        guard_cnt <= GUARD_FULL;
                        gen_rst_q <= 1'b1;
                        done_q    <= 1'b1;
                        aborted_q <= 1'b1;
                        done_id_q <= cur_id;
                    end else if (cnt == '0) begin
                        state     <= GUARD;
                        guard_cnt <= GUARD_FULL;
                        done_q    <= 1'b1;
                        done_id_q <= cur_id;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                GUARD: begin
                    if (guard_cnt == '0) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        guard_cnt <= guard_cnt - 1'b1;
                    end
                end

                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.grant_out    = grant_q;
    assign bus.busy_out     = busy_q;
    assign bus.trigger_out  = trigger_q;
    assign bus.duration_out = duration_q;
    assign bus.gen_rst_out  = gen_rst_q;
    assign bus.done_out     = done_q;
    assign bus.done_id_out  = done_id_q;
    assign bus.aborted_out  = aborted_q;
endmodule

// File: tb/tb_triangle_burst_sequencer.sv
// -----------------------------------------------------------------------------
// tb_triangle_burst_sequencer
//   Scoreboard bench for triangle_burst_sequencer (N_REQ=4, D=8, UNIT_CYCLES=4,
//   GUARD_CYCLES=2). Each scenario is planned by a transaction-level model that
//   applies the arbitration and timing rules with plain arithmetic, pushing the
//   expected output events (cycle, grant, trigger, done, abort) into a queue; a
//   monitor pops and compares whenever the DUT shows any output event.
// -----------------------------------------------------------------------------
module tb_triangle_burst_sequencer;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int U  = 4;
    localparam int G  = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    triangle_burst_sequencer_if #(.N_REQ(N), .D(DW)) bus ();

    triangle_burst_sequencer #(
        .N_REQ(N), .D(DW), .UNIT_CYCLES(U), .GUARD_CYCLES(G)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        int           c;
        logic [N-1:0] g;
        logic         tr;
        logic         dn;
        int           id;
        logic         ab;
        logic         gr;
        int           dur;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  passes = 0;
    int  cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Model state carried between scenarios
    int ptr_m     = 0;
    int next_idle = 0;

    // Scenario description
    int s_cnt[N];
    int s_dur[N];
    int s_abort_k;
    int s_abort_off;
    int s_wd;
    bit s_stray;

    function automatic void push_ev(int c, int gid, bit tr, bit dn, int id, bit ab, bit gr, int dur);
        ev_t e;
        e.c   = c;
        e.g   = (gid < 0) ? '0 : (N'(1) << gid);
        e.tr  = tr;
        e.dn  = dn;
        e.id  = id;
        e.ab  = ab;
        e.gr  = gr;
        e.dur = dur;
        exp_q.push_back(e);
    endfunction

    task automatic chk(input string name, input int got, input int req);
        checks++;
        if (got == req) passes++;
        else $display("FAIL %s: cyc %0d got %0d, required %0d", name, cyc, got, req);
    endtask

    // Monitor: every cycle with a visible output event consumes one expectation.
    always @(negedge clk) begin
        ev_t e;
        bit  ok;
        if (rst_n && (bus.grant_out != '0 || bus.trigger_out || bus.done_out || bus.gen_rst_out)) begin
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_event: cyc %0d grant %b trig %b done %b grst %b, required no event",
                         cyc, bus.grant_out, bus.trigger_out, bus.done_out, bus.gen_rst_out);
            end else begin
                e  = exp_q.pop_front();
                ok = (e.c == cyc) && (e.g == bus.grant_out) && (e.tr == bus.trigger_out) &&
                     (e.dn == bus.done_out) && (e.gr == bus.gen_rst_out) &&
                     (e.dur == int'(bus.duration_out)) &&
                     (!e.dn || (e.id == int'(bus.done_id_out) && e.ab == bus.aborted_out));
                if (ok) passes++;
                else $display("FAIL event: got cyc %0d grant %b trig %b done %b id %0d ab %b grst %b dur %0d, required cyc %0d grant %b trig %b done %b id %0d ab %b grst %b dur %0d",
                              cyc, bus.grant_out, bus.trigger_out, bus.done_out, bus.done_id_out,
                              bus.aborted_out, bus.gen_rst_out, bus.duration_out,
                              e.c, e.g, e.tr, e.dn, e.id, e.ab, e.gr, e.dur);
            end
        end
    end

    task automatic set_scn(input int c0, c1, c2, c3, d0, d1, d2, d3, ak, aoff, wd, bit stray);
        s_cnt[0] = c0; s_cnt[1] = c1; s_cnt[2] = c2; s_cnt[3] = c3;
        s_dur[0] = d0; s_dur[1] = d1; s_dur[2] = d2; s_dur[3] = d3;
        s_abort_k   = ak;
        s_abort_off = aoff;
        s_wd        = wd;
        s_stray     = stray;
    endtask

    // Plan the whole scenario from the rules, then drive it cycle by cycle.
    task automatic run_scn();
        int           pend[N];
        int           gcyc[$];
        int           gidq[$];
        bit           gdrop[$];
        int           idles[$];
        int           s, t, g, d, id, k, off, ab_cyc, first_g, first_idle;
        logic [N-1:0] req;

        @(negedge clk);
        while (cyc < next_idle) @(negedge clk);
        s = cyc;
        t = s;
        k = 0;
        ab_cyc = -1;
        first_g = -1;
        first_idle = -1;
        for (int i = 0; i < N; i++) pend[i] = s_cnt[i];

        forever begin
            id = -1;
            for (int j = 0; j < N; j++)
                if (id < 0 && pend[(ptr_m + j) % N] > 0) id = (ptr_m + j) % N;
            if (id < 0) break;
            g = t + 1;
            d = s_dur[id];
            pend[id]--;
            ptr_m = (id + 1) % N;
            push_ev(g, id, d != 0, d == 0, id, 1'b0, 1'b0, d);
            if (d == 0) begin
                t = g + 1 + G;
            end else if (k == s_abort_k) begin
                off = (s_abort_off > d * U - 1) ? d * U - 1 : s_abort_off;
                ab_cyc = g + off;
                push_ev(ab_cyc + 1, -1, 1'b0, 1'b1, id, 1'b1, 1'b1, d);
                t = ab_cyc + 2 + G;
            end else begin
                push_ev(g + d * U, -1, 1'b0, 1'b1, id, 1'b0, 1'b0, d);
                t = g + d * U + 1 + G;
            end
            if (first_g < 0) begin
                first_g = g;
                first_idle = t;
            end
            gcyc.push_back(g);
            gidq.push_back(id);
            gdrop.push_back(pend[id] == 0);
            idles.push_back(t);
            k++;
        end
        next_idle = t;

        req = '0;
        for (int i = 0; i < N; i++) begin
            if (s_cnt[i] > 0) req[i] = 1'b1;
            bus.duration_in[i*DW +: DW] = DW'(s_dur[i]);
        end

        for (int c = s; c <= t; c++) begin
            if (c > s) @(negedge clk);
            for (int q = 0; q < gcyc.size(); q++)
                if (gcyc[q] == c && gdrop[q]) req[gidq[q]] = 1'b0;
            if (s_wd >= 0 && c == first_g + 1) req[s_wd] = 1'b1;
            if (s_wd >= 0 && c == first_g + 2) req[s_wd] = 1'b0;
            bus.req_in   = req;
            bus.abort_in = (c == ab_cyc) || (s_stray && (c == first_g || c == first_idle - 1));
            #1;
            for (int q = 0; q < idles.size(); q++) begin
                if (c == idles[q])     chk("busy_low_at_idle", int'(bus.busy_out), 0);
                if (c == idles[q] - 1) chk("busy_high_in_guard", int'(bus.busy_out), 1);
            end
        end
        bus.abort_in = 1'b0;
        chk("all_events_seen", exp_q.size(), 0);
    endtask

    task automatic reset_mid_run();
        int s;
        @(negedge clk);
        while (cyc < next_idle) @(negedge clk);
        s = cyc;
        bus.duration_in = '0;
        bus.duration_in[DW-1:0] = 8'd10;
        bus.req_in = 4'b0001;
        push_ev(s + 1, 0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 10);
        @(negedge clk);
        bus.req_in = '0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("reset_clears_outputs",
            int'({bus.grant_out, bus.busy_out, bus.trigger_out, bus.duration_out,
                  bus.gen_rst_out, bus.done_out, bus.done_id_out, bus.aborted_out}), 0);
        exp_q.delete();
        ptr_m = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        next_idle = cyc;
    endtask

    initial begin
        int tot;
        rst_n = 1'b0;
        bus.req_in = '0;
        bus.duration_in = '0;
        bus.abort_in = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_state",
            int'({bus.grant_out, bus.busy_out, bus.trigger_out, bus.duration_out,
                  bus.gen_rst_out, bus.done_out, bus.done_id_out, bus.aborted_out}), 0);
        rst_n = 1'b1;
        next_idle = cyc;

        set_scn(1, 0, 0, 0, 3, 0, 0, 0, -1, 0, -1, 1'b0);  run_scn();  // single burst
        set_scn(0, 1, 0, 0, 0, 0, 0, 0, -1, 0, -1, 1'b0);  run_scn();  // zero duration
        set_scn(1, 0, 0, 0, 10, 0, 0, 0, 0, 5, -1, 1'b0);  run_scn();  // abort in RUN
        set_scn(0, 0, 1, 0, 0, 0, 2, 0, 0, 7, -1, 1'b0);   run_scn();  // abort on expiry
        set_scn(0, 0, 1, 0, 0, 0, 255, 0, -1, 0, -1, 1'b1); run_scn(); // max duration
        set_scn(0, 0, 0, 1, 0, 0, 0, 2, -1, 0, 1, 1'b1);   run_scn();  // withdrawn request
        reset_mid_run();
        set_scn(2, 1, 1, 1, 1, 1, 1, 1, -1, 0, -1, 1'b0);  run_scn();  // rotation 0,1,2,3,0

        for (int r = 0; r < 30; r++) begin
            tot = 0;
            for (int i = 0; i < N; i++) begin
                s_cnt[i] = $urandom_range(0, 2);
                s_dur[i] = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 6);
                tot += s_cnt[i];
            end
            if (tot == 0) begin
                s_cnt[$urandom_range(0, N - 1)] = 1;
                tot = 1;
            end
            s_abort_k   = ($urandom_range(0, 2) == 0) ? $urandom_range(0, tot - 1) : -1;
            s_abort_off = $urandom_range(1, 24);
            s_wd = -1;
            if ($urandom_range(0, 1) == 1)
                for (int i = 0; i < N; i++)
                    if (s_wd < 0 && s_cnt[i] == 0) s_wd = i;
            s_stray = 1'($urandom_range(0, 1));
            run_scn();
        end

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #800000;
        checks++;
        $display("FAIL watchdog: cyc %0d still running, required completion", cyc);
        $display("%0d/%0d checks passed", passes, checks);
        $fatal(1);
    end
endmodule
